// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_driver_if
//  Purpose  : Bus bundle between a controller and the multiplexed 8-tube
//             seven-segment scan driver.
//  Revision : 1.0  initial release
// ============================================================================
interface seg_scan_driver_if;
    logic [31:0] time_data;
    logic        load;
    logic [7:0]  blink_mask;
    logic        ready;
    logic [7:0]  digit1;
    logic [7:0]  digit2;
    logic [7:0]  tube_sel;
    logic        frame_done;

    modport master (
        output time_data, load, blink_mask,
        input  ready, digit1, digit2, tube_sel, frame_done
    );

    modport slave (
        input  time_data, load, blink_mask,
        output ready, digit1, digit2, tube_sel, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_driver
//  Purpose  : Time-multiplexed 8-tube seven-segment driver with frame-aligned
//             double-buffered updates and per-tube blinking.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  wire              clk,
    input  wire              rst,
    seg_scan_driver_if.slave bus
);
    localparam int c_SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
    localparam logic [31:0]          c_DISP_RST   = 32'h00F0_0F00;

    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [2:0]           r_idx;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_ph;
    logic [31:0]          r_pend;
    logic                 r_pend_vld;
    logic [31:0]          r_disp;
    logic                 r_ready;
    logic                 r_frame_done;
    logic [7:0]           r_tube_sel;
    logic [7:0]           r_digit1;
    logic [7:0]           r_digit2;

    logic                 w_scan_wrap;
    logic                 w_frame_end;
    logic [3:0]           w_nib;
    logic [7:0]           w_seg;
    logic [7:0]           w_code;

    assign w_scan_wrap = (r_scan_cnt == c_SCAN_LAST);
    assign w_frame_end = w_scan_wrap && (r_idx == 3'd0);
    assign w_nib       = r_disp[{r_idx, 2'b00} +: 4];

    // Segment order {a,b,c,d,e,f,g,dp}; codes A-E are deliberately blank.
    always_comb begin
        w_seg = 8'h00;
        case (w_nib)
            4'h0:    w_seg = 8'hFC;
            4'h1:    w_seg = 8'h60;
            4'h2:    w_seg = 8'hDA;
            4'h3:    w_seg = 8'hF2;
            4'h4:    w_seg = 8'h66;
            4'h5:    w_seg = 8'hB6;
            4'h6:    w_seg = 8'hBE;
            4'h7:    w_seg = 8'hE0;
            4'h8:    w_seg = 8'hFE;
            4'h9:    w_seg = 8'hF6;
            4'hF:    w_seg = 8'h02;
            default: w_seg = 8'h00;
        endcase
    end

    assign w_code = (r_blink_ph && bus.blink_mask[r_idx]) ? 8'h00 : w_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_idx       <= 3'd7;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else begin
            if (w_scan_wrap) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx - 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // A load in the frame-end cycle lands after the commit, so the older
    // pending word is shown and the new one waits for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend       <= 32'h0;
            r_pend_vld   <= 1'b0;
            r_disp       <= c_DISP_RST;
            r_ready      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                if (r_pend_vld) begin
                    r_disp <= r_pend;
                end
                r_pend_vld <= 1'b0;
                r_ready    <= 1'b1;
            end
            if (bus.load) begin
                r_pend     <= bus.time_data;
                r_pend_vld <= 1'b1;
                r_ready    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tube_sel <= 8'h00;
            r_digit1   <= 8'h00;
            r_digit2   <= 8'h00;
        end else begin
            r_tube_sel <= 8'h01 << r_idx;
            r_digit1   <= r_idx[2]  ? w_code : 8'h00;
            r_digit2   <= !r_idx[2] ? w_code : 8'h00;
        end
    end

    assign bus.ready      = r_ready;
    assign bus.frame_done = r_frame_done;
    assign bus.tube_sel   = r_tube_sel;
    assign bus.digit1     = r_digit1;
    assign bus.digit2     = r_digit2;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_driver
//  Purpose  : Scoreboard bench for seg_scan_driver with a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;
    localparam int SD    = 4;
    localparam int BD    = 16;
    localparam int FRAME = 8 * SD;

    typedef struct packed {
        logic [31:0] disp;
        logic [7:0]  mask;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_driver_if u_bus ();

    seg_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    frame_t     q_frame[$];
    logic       q_rdy[$];
    int         n_checks = 0;
    int         n_errors = 0;
    bit         active   = 1'b0;
    int         n_edge   = 0;
    frame_t     cur;
    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) n_edge <= 0;
        else     n_edge <= n_edge + 1;
    end

    // Monitor: expected screen content derived from cycle arithmetic and the
    // frame entry popped at the start of every displayed scan.
    always @(negedge clk) begin : mon
        int         m;
        int         idx;
        logic [7:0] code;
        if (active && n_edge > 0) begin
            m = n_edge - 1;
            if (m % FRAME == 0) begin
                if (q_frame.size() == 0) chk("frame_queue_empty", 32'd1, 32'd0);
                else                     cur = q_frame.pop_front();
            end
            idx  = 7 - ((m / SD) % 8);
            code = seg_tab[cur.disp[idx*4 +: 4]];
            if (((m / BD) % 2) == 1 && cur.mask[idx]) code = 8'h00;
            chk("tube_sel", u_bus.tube_sel, 32'(8'h01 << idx));
            chk("digit1", u_bus.digit1, (idx >= 4) ? 32'(code) : 32'h0);
            chk("digit2", u_bus.digit2, (idx <= 3) ? 32'(code) : 32'h0);
            chk("frame_done", u_bus.frame_done, (m % FRAME == FRAME - 1) ? 32'd1 : 32'd0);
            if (q_rdy.size() == 0) chk("ready_queue_empty", 32'd1, 32'd0);
            else                   chk("ready", u_bus.ready, 32'(q_rdy.pop_front()));
        end
    end

    task automatic reset_checks();
        chk("rst_tube_sel", u_bus.tube_sel, 32'h0);
        chk("rst_digit1", u_bus.digit1, 32'h0);
        chk("rst_digit2", u_bus.digit2, 32'h0);
        chk("rst_frame_done", u_bus.frame_done, 32'h0);
        chk("rst_ready", u_bus.ready, 32'h1);
    endtask

    task automatic apply_reset();
        #1;
        active       = 1'b0;
        rst          = 1'b1;
        u_bus.load   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_checks();
    endtask

    function automatic logic [7:0] pick_mask(input bit directed, input int frame);
        if (directed) return (frame == 3) ? 8'h03 : 8'h00;
        case ($urandom_range(0, 2))
            0:       return 8'h00;
            1:       return 8'h03;
            default: return 8'($urandom);
        endcase
    endfunction

    // Starts at a negedge with rst high; releases reset and drives ncyc cycles.
    task automatic run_session(input int ncyc, input bit directed);
        logic [31:0] disp;
        logic [31:0] pend;
        bit          pv;
        logic [7:0]  mask;
        frame_t      fe;
        bit          ld;
        logic [31:0] d;
        int          dl_cyc [5] = '{10, 40, 50, 70, 95};
        logic [31:0] dl_dat [5] = '{32'h12F34F56, 32'h98765432, 32'h01234567,
                                    32'hF0F1F2F3, 32'h89ABCDEF};
        q_frame.delete();
        q_rdy.delete();
        disp = 32'h00F00F00;
        pend = 32'h0;
        pv   = 1'b0;
        mask = 8'h00;
        fe.disp = disp;
        fe.mask = mask;
        q_frame.push_back(fe);
        rst    = 1'b0;
        active = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            if (n % FRAME == 0) u_bus.blink_mask = mask;
            ld = 1'b0;
            d  = $urandom;
            if (directed) begin
                for (int k = 0; k < 5; k++)
                    if (dl_cyc[k] == n) begin ld = 1'b1; d = dl_dat[k]; end
            end else begin
                ld = ($urandom_range(0, 7) == 0) ||
                     ((n % FRAME == FRAME - 1) && $urandom_range(0, 1) == 1) ||
                     (n == ncyc - 5);
            end
            u_bus.load      = ld;
            u_bus.time_data = d;
            if (n % FRAME == FRAME - 1) begin
                if (pv) disp = pend;
                pv   = 1'b0;
            end
            if (ld) begin
                pend = d;
                pv   = 1'b1;
            end
            q_rdy.push_back(!pv);
            if (n % FRAME == FRAME - 1) begin
                mask    = pick_mask(directed, n / FRAME + 1);
                fe.disp = disp;
                fe.mask = mask;
                q_frame.push_back(fe);
            end
            @(negedge clk);
        end
        u_bus.load = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        u_bus.load       = 1'b0;
        u_bus.time_data  = 32'h0;
        u_bus.blink_mask = 8'h00;
        repeat (2) @(negedge clk);
        reset_checks();
        run_session(5 * FRAME, 1'b1);
        apply_reset();
        run_session(6 * FRAME + 13, 1'b0);
        apply_reset();
        run_session(3 * FRAME, 1'b0);
        #1;
        active = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100_000, clk cycles each digit stays selected.
REQ-002 SHALL have parameter BLINK_DIV, default 25_000_000, clk cycles per blink half-period.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port time_data  input  32  eight packed nibbles, nibble k = bits [4k+3:4k], tube k; 0-9 digit, 4'hF separator.
REQ-006 SHALL have port load  input  1  single-cycle strobe requesting capture of time_data.
REQ-007 SHALL have port blink_mask  input  8  bit k=1 makes tube k blink.
REQ-008 SHALL have port ready  output  1  high when no captured update is waiting for frame end.
REQ-009 SHALL have port digit1  output  8  segments for tubes 7..4, order {a,b,c,d,e,f,g,dp}, active-high.
REQ-010 SHALL have port digit2  output  8  segments for tubes 3..0, same encoding.
REQ-011 SHALL have port tube_sel  output  8  one-hot tube enable, active-high.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each full 8-tube scan.

Function
REQ-013 SHALL keep a scan counter 0..SCAN_DIV-1 and a 3-bit index; on counter wrap the index SHALL step 7,6,...,0,7.
REQ-014 SHALL register all outputs; tube_sel, digit1, digit2 reflect the index one cycle after it changes.
REQ-015 SHALL drive tube_sel bit [index] only; digit1 carries the index's code when index>=4, else 8'h00; digit2 carries it when index<=3, else 8'h00.
REQ-016 SHALL decode nibbles: 0=FC,1=60,2=DA,3=F2,4=66,5=B6,6=BE,7=E0,8=FE,9=F6,F=02 ('-'); A-E SHALL give 00 (blank).
REQ-017 SHALL decode from an internal display register, never directly from time_data.
REQ-018 SHALL on load=1 copy time_data into a pending register and set a pending flag; ready SHALL go low the next cycle.
REQ-019 SHALL on load while pending overwrite the pending register with the newer data (last write wins).
REQ-020 SHALL at frame end (counter = SCAN_DIV-1 and index = 0) copy pending into display register, clear pending, raise ready, and pulse frame_done, all in the same cycle.
REQ-021 SHALL if load coincides with frame end commit the previously pending value (if any) and keep the new value pending.
REQ-022 SHALL free-run a blink counter 0..BLINK_DIV-1 toggling a blink phase on each wrap.
REQ-023 SHALL while blink phase=1 and blink_mask[index]=1 output 8'h00 segments for that tube, tube_sel unchanged.
REQ-024 SHALL sample blink_mask live each cycle (no capture).

Reset
REQ-025 SHALL on rst=1 at a clock edge set: scan counter 0, index 7, blink counter 0, blink phase 0, pending flag 0.
REQ-026 SHALL on reset set display register to 32'h00F00F00 ("00-00-00" with leading blanks unchanged semantics per REQ-016).
REQ-027 SHALL on reset drive tube_sel=8'h00, digit1=8'h00, digit2=8'h00, frame_done=0, ready=1.
REQ-028 SHALL on reset mid-frame discard any pending update.

Verification (SCAN_DIV=4, BLINK_DIV=16)
REQ-029 SHALL verify reset release: tube_sel visits 80,40,20,10,08,04,02,01 each for 4 cycles; digit1 on tube 7 = FC, on tube 5 = 02.
REQ-030 SHALL verify load of 32'h12F34F56 mid-frame: ready low next cycle, display unchanged until frame_done, then tube 7 shows 60, tube 0 shows BE.
REQ-031 SHALL verify two loads (A then B) within one frame: only B is ever displayed.
REQ-032 SHALL verify load in the frame-end cycle: earlier pending committed, new value committed one frame later, ready low throughout.
REQ-033 SHALL verify blink_mask=8'h03: tubes 1,0 show 00 for 16 cycles then codes for 16 cycles, others never blank.
REQ-034 SHALL verify rst asserted with pending data: after release ready=1, display shows 00-00-00 default, frame_done first pulses after 32 cycles.
